// File: rtl/spi_block_engine.sv
// Block-transfer sequencer in front of the spiio SD-card SPI controller.
// Moves one data block between card and local buffer; CPU passes through to spiio when idle.
module spi_block_engine #(
    parameter int unsigned BLOCK_LEN = 512,
    parameter int unsigned SETTLE    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    input  logic       spi_cs,
    output logic [2:0] m_ad,
    output logic [7:0] m_do,
    input  logic [7:0] m_di,
    output logic       m_rw,
    output logic       m_cs,
    output logic [8:0] buf_addr,
    output logic [7:0] buf_wdata,
    output logic       buf_we,
    input  logic [7:0] buf_rdata,
    output logic       busy
);

    localparam logic [8:0] LastAddr  = 9'(BLOCK_LEN - 1);
    localparam logic [7:0] SettleCnt = 8'(SETTLE);

    typedef enum logic [2:0] {
        StIdle, StTokTx, StTokPoll, StData, StCrc, StResp, StDone
    } state_e;

    typedef enum logic [2:0] {
        XfWr, XfSettle, XfPoll, XfPollChk, XfRd, XfRdChk
    } xfer_e;

    state_e      r_st;
    xfer_e       r_xf;
    logic [7:0]  r_cnt;
    logic        r_e_cs;
    logic        r_e_rw;
    logic [2:0]  r_e_ad;
    logic [7:0]  r_e_do;
    logic        r_busy;
    logic        r_done;
    logic        r_tokerr;
    logic        r_dir;
    logic [7:0]  r_token;
    logic [7:0]  r_timeout;
    logic [7:0]  r_crch;
    logic [7:0]  r_crcl;
    logic [7:0]  r_resp;
    logic [8:0]  r_addr;
    logic        r_last;
    logic [16:0] r_polls;
    logic [3:0]  r_idx;
    logic [7:0]  r_do;
    logic        r_pt_rd;

    logic        w_start;
    logic        w_fin;
    logic        w_err;
    logic [16:0] w_poll_lim;
    logic [7:0]  w_rd_val;
    logic [7:0]  w_e_do;

    assign w_start = cs && !rw && (AD == 3'd0) && DI[0] && !r_busy;

    // Outcome of the byte just received; only meaningful in XfRdChk.
    always_comb begin
        w_poll_lim = (r_timeout == 8'h00) ? 17'h10000 : {1'b0, r_timeout, 8'h00};
        w_fin      = 1'b0;
        w_err      = 1'b0;
        unique case (r_st)
            StTokPoll: begin
                if (m_di != r_token) begin
                    if (m_di != 8'hFF || (r_polls + 17'd1) == w_poll_lim) begin
                        w_fin = 1'b1;
                        w_err = 1'b1;
                    end
                end
            end
            StCrc:  w_fin = (r_idx == 4'd1) && !r_dir;
            StResp: begin
                w_fin = (m_di != 8'hFF) || (r_idx == 4'd7);
                w_err = (m_di[4:0] != 5'b00101);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rd_val = 8'h00;
        case (AD)
            3'd0:    w_rd_val = {r_busy, r_done, r_tokerr, 3'b000, r_dir, 1'b0};
            3'd1:    w_rd_val = r_token;
            3'd2:    w_rd_val = r_timeout;
            3'd3:    w_rd_val = r_crch;
            3'd4:    w_rd_val = r_crcl;
            3'd5:    w_rd_val = r_resp;
            default: w_rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_st      <= StIdle;
            r_xf      <= XfWr;
            r_cnt     <= 8'h00;
            r_e_cs    <= 1'b0;
            r_e_rw    <= 1'b1;
            r_e_ad    <= 3'd0;
            r_e_do    <= 8'hFF;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tokerr  <= 1'b0;
            r_dir     <= 1'b0;
            r_token   <= 8'hFE;
            r_timeout <= 8'h01;
            r_crch    <= 8'hFF;
            r_crcl    <= 8'hFF;
            r_resp    <= 8'hFF;
            r_addr    <= 9'd0;
            r_last    <= 1'b0;
            r_polls   <= 17'd0;
            r_idx     <= 4'd0;
            r_do      <= 8'h00;
            r_pt_rd   <= 1'b0;
        end else begin
            r_e_cs <= 1'b0;

            if (cs && rw) begin
                r_do    <= w_rd_val;
                r_pt_rd <= 1'b0;
            end else if (spi_cs && rw) begin
                r_pt_rd <= !r_busy;
                if (r_busy) r_do <= 8'hFF;
            end

            if (cs && !rw && !r_busy) begin
                case (AD)
                    3'd0:    r_dir     <= DI[1];
                    3'd1:    r_token   <= DI;
                    3'd2:    r_timeout <= DI;
                    default: ;
                endcase
            end

            if (w_start) begin
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
                r_tokerr <= 1'b0;
                r_addr   <= 9'd0;
                r_last   <= 1'b0;
                r_polls  <= 17'd0;
                r_idx    <= 4'd0;
                r_st     <= DI[1] ? StTokTx : StTokPoll;
                r_xf     <= XfWr;
                r_e_cs   <= 1'b1;
                r_e_rw   <= 1'b0;
                r_e_ad   <= 3'd1;
                r_e_do   <= DI[1] ? r_token : 8'hFF;
            end else if (r_st == StDone) begin
                r_st <= StIdle;
            end else if (r_st != StIdle) begin
                case (r_xf)
                    XfWr: begin
                        if (SettleCnt == 8'd0) begin
                            r_xf   <= XfPoll;
                            r_e_cs <= 1'b1;
                            r_e_rw <= 1'b1;
                            r_e_ad <= 3'd2;
                        end else begin
                            r_xf  <= XfSettle;
                            r_cnt <= SettleCnt;
                        end
                    end
                    XfSettle: begin
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_xf   <= XfPoll;
                            r_e_cs <= 1'b1;
                            r_e_rw <= 1'b1;
                            r_e_ad <= 3'd2;
                        end
                    end
                    XfPoll: r_xf <= XfPollChk;
                    XfPollChk: begin
                        r_e_cs <= 1'b1;
                        r_e_rw <= 1'b1;
                        if (m_di[7]) begin
                            r_xf   <= XfRd;
                            r_e_ad <= 3'd1;
                        end else begin
                            r_xf   <= XfPoll;
                            r_e_ad <= 3'd2;
                        end
                    end
                    XfRd: begin
                        r_xf <= XfRdChk;
                        // Write direction advances early so buf_rdata is ready for the next send.
                        if (r_st == StData && r_dir) begin
                            if (r_addr == LastAddr) r_last <= 1'b1;
                            else                    r_addr <= r_addr + 9'd1;
                        end
                    end
                    XfRdChk: begin
                        case (r_st)
                            StTokTx: r_st <= StData;
                            StTokPoll: begin
                                if (m_di == r_token) r_st    <= StData;
                                else if (!w_fin)     r_polls <= r_polls + 17'd1;
                            end
                            StData: begin
                                if (r_dir ? r_last : (r_addr == LastAddr)) begin
                                    r_st  <= StCrc;
                                    r_idx <= 4'd0;
                                end else if (!r_dir) begin
                                    r_addr <= r_addr + 9'd1;
                                end
                            end
                            StCrc: begin
                                if (!r_dir) begin
                                    if (r_idx == 4'd0) r_crch <= m_di;
                                    else               r_crcl <= m_di;
                                end
                                if (r_idx == 4'd1) begin
                                    r_idx <= 4'd0;
                                    if (r_dir) r_st <= StResp;
                                end else begin
                                    r_idx <= r_idx + 4'd1;
                                end
                            end
                            StResp: begin
                                r_idx <= r_idx + 4'd1;
                                if (w_fin) r_resp <= m_di;
                            end
                            default: ;
                        endcase
                        if (w_fin) begin
                            r_st     <= StDone;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_tokerr <= w_err;
                        end else begin
                            r_xf   <= XfWr;
                            r_e_cs <= 1'b1;
                            r_e_rw <= 1'b0;
                            r_e_ad <= 3'd1;
                            r_e_do <= 8'hFF;
                        end
                    end
                    default: r_xf <= XfWr;
                endcase
            end
        end
    end

    assign w_e_do    = (r_st == StData && r_dir) ? buf_rdata : r_e_do;

    assign m_cs      = r_busy ? r_e_cs : spi_cs;
    assign m_rw      = r_busy ? r_e_rw : rw;
    assign m_ad      = r_busy ? r_e_ad : AD;
    assign m_do      = r_busy ? w_e_do : DI;

    assign buf_addr  = r_addr;
    assign buf_wdata = m_di;
    assign buf_we    = (r_st == StData) && !r_dir && (r_xf == XfRdChk);
    assign busy      = r_busy;
    assign DO        = (r_pt_rd && !r_busy) ? m_di : r_do;

endmodule
